// File: rtl/multi_button_dejitter.sv
// Multi-channel button debouncer: per-channel input inversion, 2-flop
// synchroniser, stable-count filter, press/release strobes and optional
// long-press / auto-repeat strobe.
module multi_button_dejitter #(
  parameter int                  CHANNELS     = 4,
  parameter int                  COUNT_TO     = 250000,
  parameter int                  HOLD_COUNT   = 0,
  parameter int                  REPEAT_COUNT = 0,
  parameter logic [CHANNELS-1:0] INVERT       = '0
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [CHANNELS-1:0] BTN_IN,
  output logic [CHANNELS-1:0] BTN_OUT,
  output logic [CHANNELS-1:0] BTN_PRESS,
  output logic [CHANNELS-1:0] BTN_RELEASE,
  output logic [CHANNELS-1:0] BTN_HOLD
);

  localparam int CW     = $clog2(COUNT_TO + 1);
  localparam int HMAX   = (HOLD_COUNT > REPEAT_COUNT) ? HOLD_COUNT : REPEAT_COUNT;
  localparam int HW_RAW = $clog2(HMAX + 1);
  localparam int HW     = (HW_RAW < 1) ? 1 : HW_RAW;

  localparam logic [CW-1:0] CNT_LAST  = CW'(COUNT_TO - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_COUNT > 0) ? HOLD_COUNT - 1 : 0);
  localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_COUNT > 0) ? REPEAT_COUNT - 1 : 0);

  logic [CHANNELS-1:0] s0, s1;
  logic [CHANNELS-1:0] rise, fall;
  logic [CHANNELS-1:0] held;
  logic [CW-1:0]       cnt  [CHANNELS];
  logic [HW-1:0]       hcnt [CHANNELS];

  // Invert active-low channels and bring the raw inputs into the clock domain.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s0 <= '0;
      s1 <= '0;
    end else begin
      s0 <= BTN_IN ^ INVERT;
      s1 <= s0;
    end
  end

  // A level change is accepted on the edge that completes COUNT_TO stable cycles.
  always_comb begin
    rise = '0;
    fall = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      rise[i] = s1[i] & ~BTN_OUT[i] & (cnt[i] == CNT_LAST);
      fall[i] = ~s1[i] & BTN_OUT[i] & (cnt[i] == CNT_LAST);
    end
  end

  // Stability counter, debounced level and press/release strobes.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      BTN_OUT     <= '0;
      BTN_PRESS   <= '0;
      BTN_RELEASE <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      BTN_OUT     <= BTN_OUT ^ (rise | fall);
      BTN_PRESS   <= rise;
      BTN_RELEASE <= fall;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if ((s1[i] == BTN_OUT[i]) || (cnt[i] == CNT_LAST)) cnt[i] <= '0;
        else                                              cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Long-press timer: 'held' marks that the first hold strobe has fired, after
  // which the same counter is reused as the repeat period timer.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      BTN_HOLD <= '0;
      held     <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) hcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        BTN_HOLD[i] <= 1'b0;
        if ((HOLD_COUNT == 0) || rise[i] || fall[i] || !BTN_OUT[i]) begin
          hcnt[i] <= '0;
          held[i] <= 1'b0;
        end else if (!held[i]) begin
          if (hcnt[i] == HOLD_LAST) begin
            BTN_HOLD[i] <= 1'b1;
            held[i]     <= 1'b1;
            hcnt[i]     <= '0;
          end else begin
            hcnt[i] <= hcnt[i] + 1'b1;
          end
        end else if (REPEAT_COUNT > 0) begin
          if (hcnt[i] == REP_LAST) begin
            BTN_HOLD[i] <= 1'b1;
            hcnt[i]     <= '0;
          end else begin
            hcnt[i] <= hcnt[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_button_dejitter.sv
// Directed testbench for multi_button_dejitter: three instances cover
// plain debouncing with an inverted channel, hold with repeat, and single hold.
module tb_multi_button_dejitter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_a;
  logic [3:0] out_a, press_a, rel_a, hold_a;
  logic [1:0] btn_b;
  logic [1:0] out_b, press_b, rel_b, hold_b;
  logic [1:0] out_c, press_c, rel_c, hold_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multi_button_dejitter #(
    .CHANNELS(4), .COUNT_TO(8), .HOLD_COUNT(0), .REPEAT_COUNT(0), .INVERT(4'b0100)
  ) dut_a (
    .CLK(clk), .RST_N(rst_n), .BTN_IN(btn_a),
    .BTN_OUT(out_a), .BTN_PRESS(press_a), .BTN_RELEASE(rel_a), .BTN_HOLD(hold_a)
  );

  multi_button_dejitter #(
    .CHANNELS(2), .COUNT_TO(4), .HOLD_COUNT(10), .REPEAT_COUNT(5), .INVERT(2'b00)
  ) dut_b (
    .CLK(clk), .RST_N(rst_n), .BTN_IN(btn_b),
    .BTN_OUT(out_b), .BTN_PRESS(press_b), .BTN_RELEASE(rel_b), .BTN_HOLD(hold_b)
  );

  multi_button_dejitter #(
    .CHANNELS(2), .COUNT_TO(4), .HOLD_COUNT(10), .REPEAT_COUNT(0), .INVERT(2'b00)
  ) dut_c (
    .CLK(clk), .RST_N(rst_n), .BTN_IN(btn_b),
    .BTN_OUT(out_c), .BTN_PRESS(press_c), .BTN_RELEASE(rel_c), .BTN_HOLD(hold_c)
  );

  // Advance one rising edge and settle just after it.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [3:0] exp;
    rst_n = 1'b0;
    btn_a = 4'b0100;
    btn_b = 2'b00;
    for (int e = 1; e <= 8; e++) begin
      if (e == 6) rst_n = 1'b1;
      step();
      tests++;
      if ({out_a, press_a, rel_a, hold_a} !== 16'h0) begin
        fails++;
        $display("FAIL reset_idle_a e=%0d got=%h exp=0000", e, {out_a, press_a, rel_a, hold_a});
      end
      tests++;
      if ({out_b, press_b, rel_b, hold_b, out_c, press_c, rel_c, hold_c} !== 16'h0) begin
        fails++;
        $display("FAIL reset_idle_bc e=%0d got=%h exp=0000", e,
                 {out_b, press_b, rel_b, hold_b, out_c, press_c, rel_c, hold_c});
      end
    end
    // Reset in the middle of a debounce (count about 5) discards progress.
    btn_a[0] = 1'b1;
    repeat (7) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tests++;
    if (out_a !== 4'b0000) begin
      fails++;
      $display("FAIL reset_mid_debounce got=%b exp=0000", out_a);
    end
    for (int e = 1; e <= 10; e++) begin
      step();
      exp = {3'b000, e == 10};
      tests++;
      if (out_a !== exp || press_a !== exp) begin
        fails++;
        $display("FAIL reset_fresh_delay e=%0d out=%b press=%b exp=%b", e, out_a, press_a, exp);
      end
    end
    btn_a[0] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      tests++;
      if (out_a[0] !== (e < 10) || rel_a[0] !== (e == 10)) begin
        fails++;
        $display("FAIL reset_recover_release e=%0d out=%b rel=%b", e, out_a[0], rel_a[0]);
      end
    end
  endtask

  task automatic test_press_release;
    logic [3:0] exp_out, exp_press, exp_rel;
    btn_a[0] = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      exp_out   = {3'b000, e >= 10};
      exp_press = {3'b000, e == 10};
      tests++;
      if (out_a !== exp_out || press_a !== exp_press || rel_a !== 4'b0000) begin
        fails++;
        $display("FAIL press e=%0d out=%b press=%b rel=%b exp_out=%b exp_press=%b",
                 e, out_a, press_a, rel_a, exp_out, exp_press);
      end
    end
    btn_a[0] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      exp_out = {3'b000, e < 10};
      exp_rel = {3'b000, e == 10};
      tests++;
      if (out_a !== exp_out || rel_a !== exp_rel || press_a !== 4'b0000) begin
        fails++;
        $display("FAIL release e=%0d out=%b rel=%b press=%b exp_out=%b exp_rel=%b",
                 e, out_a, rel_a, press_a, exp_out, exp_rel);
      end
    end
  endtask

  task automatic test_bounce;
    logic pat;
    // high 6, low 2, high 5, then low: never stable for 8 cycles
    for (int k = 0; k < 25; k++) begin
      pat = (k < 6) || (k >= 8 && k < 13);
      btn_a[1] = pat;
      step();
      tests++;
      if (out_a[1] !== 1'b0 || press_a[1] !== 1'b0 || rel_a[1] !== 1'b0) begin
        fails++;
        $display("FAIL bounce_idle k=%0d out=%b press=%b rel=%b exp=000", k, out_a[1], press_a[1], rel_a[1]);
      end
    end
    btn_a[1] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      tests++;
      if (out_a[1] !== (e >= 10) || press_a[1] !== (e == 10)) begin
        fails++;
        $display("FAIL bounce_clean_press e=%0d out=%b press=%b", e, out_a[1], press_a[1]);
      end
    end
    for (int k = 0; k < 25; k++) begin
      pat = (k < 6) || (k >= 8 && k < 13);
      btn_a[1] = ~pat;
      step();
      tests++;
      if (out_a[1] !== 1'b1 || press_a[1] !== 1'b0 || rel_a[1] !== 1'b0) begin
        fails++;
        $display("FAIL bounce_pressed k=%0d out=%b press=%b rel=%b exp=100", k, out_a[1], press_a[1], rel_a[1]);
      end
    end
    btn_a[1] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      tests++;
      if (out_a[1] !== (e < 10) || rel_a[1] !== (e == 10)) begin
        fails++;
        $display("FAIL bounce_clean_release e=%0d out=%b rel=%b", e, out_a[1], rel_a[1]);
      end
    end
  endtask

  // Press sampled at edges 1..40: P = 6, R = 46.
  task automatic test_long_press;
    logic exp_out, exp_hb, exp_hc;
    for (int e = 1; e <= 55; e++) begin
      btn_b = {1'b0, e <= 40};
      step();
      exp_out = (e >= 6) && (e < 46);
      exp_hb  = (e >= 16) && (e < 46) && (((e - 16) % 5) == 0);
      exp_hc  = (e == 16);
      tests++;
      if (out_b !== {1'b0, exp_out} || press_b !== {1'b0, e == 6} || rel_b !== {1'b0, e == 46}) begin
        fails++;
        $display("FAIL hold_level_b e=%0d out=%b press=%b rel=%b", e, out_b, press_b, rel_b);
      end
      tests++;
      if (hold_b !== {1'b0, exp_hb}) begin
        fails++;
        $display("FAIL hold_repeat e=%0d got=%b exp=%b", e, hold_b, {1'b0, exp_hb});
      end
      tests++;
      if (hold_c !== {1'b0, exp_hc} || out_c !== {1'b0, exp_out}) begin
        fails++;
        $display("FAIL hold_single e=%0d hold=%b out=%b exp_hold=%b", e, hold_c, out_c, {1'b0, exp_hc});
      end
    end
  endtask

  // Staggered presses on ch0/ch2/ch3; ch2 is active-low. pe/re = first edge
  // sampling the pressed/released level; output follows 9 edges later.
  task automatic test_polarity_independence;
    int pe [4];
    int re [4];
    logic [3:0] exp_out, exp_press, exp_rel;
    pe = '{4, 1000, 1, 8};
    re = '{23, 1000, 21, 31};
    for (int e = 1; e <= 45; e++) begin
      for (int c = 0; c < 4; c++) begin
        btn_a[c] = (e >= pe[c] && e < re[c]) ^ (c == 2);
        exp_out[c]   = (e >= pe[c] + 9) && (e < re[c] + 9);
        exp_press[c] = (e == pe[c] + 9);
        exp_rel[c]   = (e == re[c] + 9);
      end
      step();
      tests++;
      if (out_a !== exp_out || press_a !== exp_press || rel_a !== exp_rel) begin
        fails++;
        $display("FAIL polarity_indep e=%0d out=%b press=%b rel=%b exp_out=%b exp_press=%b exp_rel=%b",
                 e, out_a, press_a, rel_a, exp_out, exp_press, exp_rel);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn_a = 4'b0100;
    btn_b = 2'b00;
    test_reset();
    test_press_release();
    test_bounce();
    test_long_press();
    test_polarity_independence();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
